// File: rtl/dmem_lsu.sv
// Word-organised data memory with an integrated load/store unit: size-encoded requests,
// internal byte-lane generation, load extension, fault detection and configurable read latency.
module dmem_lsu #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        ld_ok_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] rword_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          mem_en;
    logic [31:0]   off;
    logic          fault;
    logic [AW-1:0] widx;
    logic [3:0]    mask;
    logic [31:0]   wdata_rep;
    logic [31:0]   shifted;
    logic [31:0]   ld_data;

    // Handshakes: a request transfers on any edge where req_valid && req_ready, a response
    // on any edge where resp_valid && resp_ready; a raised valid holds its payload until it transfers.
    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign mem_en    = accept && !fault && !reset;

    assign off  = req_addr - BASE_ADDR;
    assign widx = off[AW+1:2];

    always_comb begin
        fault     = ({1'b0, off} >= MEM_BYTES);
        mask      = 4'b1111;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                mask      = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                mask      = 4'b0011 << req_addr[1:0];
                wdata_rep = {2{req_wdata[15:0]}};
                if (req_addr[0]) fault = 1'b1;
            end
            2'b10: begin
                if (req_addr[1:0] != 2'b00) fault = 1'b1;
            end
            default: fault = 1'b1;
        endcase
    end

    // RAM is deliberately not reset so stored data survives a core reset.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) mem[widx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
                end
            end else begin
                rword_q <= mem[widx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            ld_ok_q      <= 1'b0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        resp_err_q <= fault;
                        ld_ok_q    <= !req_we && !fault;
                        off_q      <= req_addr[1:0];
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        if (req_we || READ_LAT == 1) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 3'(READ_LAT - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 3'd1) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        cnt_q        <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        ld_ok_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign shifted = rword_q >> {off_q, 3'b000};

    always_comb begin
        ld_data = rword_q;
        case (size_q)
            2'b00:   ld_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ld_data = rword_q;
        endcase
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q && resp_err_q;
    assign resp_rdata = (resp_valid_q && ld_ok_q) ? ld_data : 32'h0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: three instances (READ_LAT 1, 3, 4) on a 64-word memory,
// one task per scenario with hand-computed expectations.
module tb_dmem_lsu;

    localparam int D1 = 0;
    localparam int D3 = 1;
    localparam int D4 = 2;

    logic        clk;
    logic        reset;
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_addr     [3];
    logic [31:0] req_wdata    [3];
    logic        resp_valid   [3];
    logic        resp_ready   [3];
    logic [31:0] resp_rdata   [3];
    logic        resp_err     [3];
    logic [1:0]  dbg_state    [3];

    int total;
    int bad;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_lsu #(
            .DEPTH_WORDS(64),
            .READ_LAT   (g == 0 ? 1 : (g == 1 ? 3 : 4)),
            .BASE_ADDR  (32'h0)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_we      (req_we[g]),
            .req_size    (req_size[g]),
            .req_unsigned(req_unsigned[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_err    (resp_err[g]),
            .dbg_state   (dbg_state[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int lat_of(input int d);
        return (d == D1) ? 1 : ((d == D3) ? 3 : 4);
    endfunction

    task automatic drive_req(input int d, input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
    endtask

    // Full transaction; lat = negedges from accept edge to resp_valid, -1 on timeout.
    task automatic txn(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err);
        int n;
        lat   = -1;
        rdata = 32'hxxxx_xxxx;
        err   = 1'bx;
        @(negedge clk);
        drive_req(d, we, size, uns, addr, wdata);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid[d]) begin
                lat   = c;
                rdata = resp_rdata[d];
                err   = resp_err[d];
                break;
            end
        end
        if (lat < 0) return;
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (resp_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", d, resp_valid[d]); end
            total++;
            if (resp_rdata[d] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, resp_rdata[d]); end
            total++;
            if (resp_err[d] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", d, resp_err[d]); end
            total++;
            if (dbg_state[d] !== 2'd0) begin bad++; $display("FAIL reset_state[%0d]: got %0d want 0", d, dbg_state[d]); end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d]: got %b want 1", d, req_ready[d]); end
        end
    endtask

    task automatic test_word_store_load();
        int lat;
        logic [31:0] rd;
        logic er;
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
            total++;
            if (lat !== 1) begin bad++; $display("FAIL word_st_lat[%0d]: got %0d want 1", d, lat); end
            total++;
            if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL word_st_resp[%0d]: got %h/%b want 0/0", d, rd, er); end
            txn(d, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
            total++;
            if (lat !== lat_of(d)) begin bad++; $display("FAIL word_ld_lat[%0d]: got %0d want %0d", d, lat, lat_of(d)); end
            total++;
            if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_ld_data[%0d]: got %h want deadbeef", d, rd); end
            total++;
            if (er !== 1'b0) begin bad++; $display("FAIL word_ld_err[%0d]: got %b want 0", d, er); end
        end
    endtask

    task automatic test_byte_ext();
        int lat;
        logic [31:0] rd;
        logic er;
        txn(D1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, er);
        txn(D1, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80, lat, rd, er);
        total++;
        if (er !== 1'b0) begin bad++; $display("FAIL byte_st_err: got %b want 0", er); end
        txn(D1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_ld_signed: got %h want ffffff80", rd); end
        txn(D1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h00000080) begin bad++; $display("FAIL byte_ld_unsigned: got %h want 00000080", rd); end
        txn(D1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h11228044) begin bad++; $display("FAIL byte_word_view: got %h want 11228044", rd); end
        txn(D1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h00000011) begin bad++; $display("FAIL byte_ld_lane3: got %h want 00000011", rd); end
    endtask

    task automatic test_half_lanes();
        int lat;
        logic [31:0] rd;
        logic er;
        txn(D3, 1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, lat, rd, er);
        txn(D3, 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFFA55A, lat, rd, er);
        txn(D3, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hA55A5678) begin bad++; $display("FAIL half_word_view: got %h want a55a5678", rd); end
        txn(D3, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hFFFFA55A) begin bad++; $display("FAIL half_ld_signed: got %h want ffffa55a", rd); end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL half_ld_lat: got %0d want 3", lat); end
        txn(D3, 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h00005678) begin bad++; $display("FAIL half_ld_low: got %h want 00005678", rd); end
        txn(D3, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h0000A55A) begin bad++; $display("FAIL half_ld_unsigned: got %h want 0000a55a", rd); end
    endtask

    task automatic test_faults();
        int lat;
        logic [31:0] rd;
        logic er;
        logic [31:0] f_addr [5];
        logic        f_we   [5];
        logic [1:0]  f_size [5];
        f_addr = '{32'h33, 32'h42, 32'h40, 32'h100, 32'h100};
        f_we   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        f_size = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
        txn(D1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h01020304, lat, rd, er);
        txn(D1, 1'b1, 2'b10, 1'b0, 32'h00, 32'h0BADF00D, lat, rd, er);
        txn(D1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, lat, rd, er);
        for (int i = 0; i < 5; i++) begin
            txn(D1, f_we[i], f_size[i], 1'b0, f_addr[i], 32'hFFFFFFFF, lat, rd, er);
            total++;
            if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
                bad++;
                $display("FAIL fault_%0d: got err=%b rdata=%h lat=%0d want err=1 rdata=0 lat=1", i, er, rd, lat);
            end
        end
        txn(D1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h01020304) begin bad++; $display("FAIL fault_mem30: got %h want 01020304", rd); end
        txn(D1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL fault_mem40: got %h want cafef00d", rd); end
        txn(D1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL fault_mem00: got %h want 0badf00d", rd); end
        txn(D3, 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, lat, rd, er);
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
            bad++;
            $display("FAIL fault_lat3: got err=%b rdata=%h lat=%0d want err=1 rdata=0 lat=3", er, rd, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] rd;
        logic er;
        txn(D3, 1'b1, 2'b10, 1'b0, 32'h50, 32'h5A5AA5A5, lat, rd, er);
        @(negedge clk);
        drive_req(D3, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        @(posedge clk);
        #1 req_valid[D3] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid[D3]) begin lat = c; break; end
        end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL bp_lat: got %0d want 3", lat); end
        drive_req(D3, 1'b1, 2'b10, 1'b0, 32'h54, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (resp_valid[D3] !== 1'b1 || resp_rdata[D3] !== 32'h5A5AA5A5 || req_ready[D3] !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: got valid=%b rdata=%h ready=%b want 1/5a5aa5a5/0",
                         i, resp_valid[D3], resp_rdata[D3], req_ready[D3]);
            end
            @(negedge clk);
        end
        resp_ready[D3] = 1'b1;
        @(posedge clk);
        #1 resp_ready[D3] = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready[D3] !== 1'b1 || resp_valid[D3] !== 1'b0 || dbg_state[D3] !== 2'd0) begin
            bad++;
            $display("FAIL bp_after_hs: got ready=%b valid=%b state=%0d want 1/0/0",
                     req_ready[D3], resp_valid[D3], dbg_state[D3]);
        end
        @(posedge clk);
        #1 req_valid[D3] = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid[D3] !== 1'b1 || dbg_state[D3] !== 2'd2 || resp_err[D3] !== 1'b0) begin
            bad++;
            $display("FAIL bp_b2b_store: got valid=%b state=%0d err=%b want 1/2/0",
                     resp_valid[D3], dbg_state[D3], resp_err[D3]);
        end
        resp_ready[D3] = 1'b1;
        @(posedge clk);
        #1 resp_ready[D3] = 1'b0;
        txn(D3, 1'b0, 2'b10, 1'b0, 32'h54, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h12345678) begin bad++; $display("FAIL bp_b2b_data: got %h want 12345678", rd); end
    endtask

    task automatic test_reset_wait();
        int lat;
        logic [31:0] rd;
        logic er;
        logic seen;
        txn(D4, 1'b1, 2'b10, 1'b0, 32'h60, 32'h600DC0DE, lat, rd, er);
        @(negedge clk);
        drive_req(D4, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
        @(posedge clk);
        #1 req_valid[D4] = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_state[D4] !== 2'd1) begin bad++; $display("FAIL rw_in_wait: got %0d want 1", dbg_state[D4]); end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid[D4] !== 1'b0 || req_ready[D4] !== 1'b1) begin
            bad++;
            $display("FAIL rw_after_reset: got valid=%b ready=%b want 0/1", resp_valid[D4], req_ready[D4]);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[D4]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rw_no_stale_resp: got %b want 0", seen); end
        txn(D4, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h600DC0DE || lat !== 4) begin
            bad++;
            $display("FAIL rw_persist: got %h lat=%0d want 600dc0de lat=4", rd, lat);
        end
        txn(D1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_persist_d1: got %h want deadbeef", rd); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_size[d]     = 2'b00;
            req_unsigned[d] = 1'b0;
            req_addr[d]     = 32'h0;
            req_wdata[d]    = 32'h0;
            resp_ready[d]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        test_word_store_load();
        test_byte_ext();
        test_half_lanes();
        test_faults();
        test_backpressure();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised data memory with an integrated load/store unit. It is the successor to the single-cycle, mask-driven data RAM.
- Accepts size-encoded load/store requests over a valid/ready handshake and generates byte lanes internally.
- Sign- or zero-extends load data, returns it after a configurable read latency, and flags misaligned or out-of-range accesses.
- Sits between the core's memory stage and word-organised RAM, so the core can move to a multi-cycle or stalled pipeline.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 16.
- READ_LAT, 1: cycles from load acceptance to resp_valid; range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  access faulted.

Behaviour:
- Single outstanding request.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE.
  - Accept = req_valid & req_ready.
- Fault is computed at accept. Any one of these conditions faults:
  - req_size = 11.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - (addr - BASE_ADDR) >= DEPTH_WORDS*4, as an unsigned compare.
- Word index = (addr - BASE_ADDR) >> 2, using its low log2(DEPTH_WORDS) bits.
- Byte-lane mask, from addr[1:0]:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
  - Store data is replicated across lanes (byte x4, half x2).
- Store:
  - Accepted, non-faulting store writes the enabled lanes at the accept edge.
  - A faulting store writes nothing.
  - Next state RESP, so resp_valid rises the cycle after accept, with rdata = 0 and err as computed.
- Load:
  - The RAM word is read into a register at the accept edge. Offset, size and unsigned flag are latched with it.
  - READ_LAT = 1: next state RESP.
  - READ_LAT > 1: next state WAIT, counting READ_LAT-1 cycles, then RESP.
  - resp_valid is therefore asserted exactly READ_LAT cycles after the accept edge.
  - The selected lane is shifted down and extended from bit 7 (byte) or bit 15 (half) unless unsigned.
  - A faulting load follows the same timing, with rdata = 0 and err = 1; no RAM access is required.
- Response hold: in RESP, resp_valid stays 1 and rdata/err stay stable until resp_ready = 1. That edge returns the FSM to IDLE.
- Back-to-back: a new request can be accepted the cycle after the handshake completes. Minimum 2 cycles per store, READ_LAT+1 per load.
- Ordering: a load accepted after a store to the same word returns the stored data. This holds by construction, since there is only one outstanding request.
- Reset:
  - State = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, latency counter = 0.
  - req_ready is 1 from the first cycle after reset.
  - Reset mid-WAIT or mid-RESP discards the pending response.
  - RAM contents are not reset; a write completed before reset persists.
- Inputs are ignored when req_ready = 0. resp_ready is ignored when resp_valid = 0.

Test Plan:
- Word store then load: store 32'hDEADBEEF @0x10 size 10, then load @0x10. Required: resp_rdata = DEADBEEF, err = 0, resp_valid exactly READ_LAT cycles after load accept (check READ_LAT = 1 and 3).
- Byte stores and extension: store 8'h80 @0x21, then load @0x21 size 00 signed and unsigned. Required: FFFFFF80, then 00000080. Word load @0x20 shows only byte 1 changed.
- Half lanes: store 16'hA55A @0x32, then word load @0x30. Required: [31:16] = A55A, [15:0] unchanged. Signed half load @0x32 returns FFFFA55A.
- Faults: half @0x33, word @0x42, size 11, and addr BASE_ADDR + DEPTH_WORDS*4. Required for each: err = 1, rdata = 0, memory unchanged when re-read.
- Backpressure: hold resp_ready = 0 for 5 cycles. Required: resp_valid and data stable, req_ready = 0, a new req_valid is not accepted until the cycle after the handshake.
- Reset during WAIT with READ_LAT = 4: required resp_valid = 0 and req_ready = 1 next cycle; a previously written word still reads back correctly.
